// File: rtl/int_div_seq.sv
// int_div_seq: sequential restoring integer divider with valid/ready
// handshakes on both the operand and the result side. One quotient bit is
// produced per clock, MSB first, on operand magnitudes; signs are restored
// on the final edge so signed results truncate toward zero.
// Divide-by-zero and the signed most-negative / -1 overflow case finish on
// the accept edge without iterating.
// Optional feature: define INT_DIV_REM_EN to drive the remainder on R;
// without it R is tied to zero and no remainder output register exists.
module int_div_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  SIGNED,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] R
);

  localparam int                    CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Absolute value of an operand; unsigned operands pass through untouched.
  function automatic logic [DATA_WIDTH-1:0] magnitude(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  is_signed
  );
    return (is_signed && v[DATA_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // Two's-complement negate when the result must carry a negative sign.
  function automatic logic [DATA_WIDTH-1:0] apply_sign(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  neg
  );
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Control state and registered outputs
  state_t                  state_q,     state_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic                    in_ready_q,  in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   q_out_q,     q_out_d;
`ifdef INT_DIV_REM_EN
  logic [DATA_WIDTH-1:0]   r_out_q,     r_out_d;
  logic                    rneg_q,      rneg_d;
`endif

  // Iteration datapath: partial remainder, shifting dividend/quotient,
  // divisor magnitude and the quotient sign captured at accept.
  logic [DATA_WIDTH-1:0]   rem_q,       rem_d;
  logic [DATA_WIDTH-1:0]   quo_q,       quo_d;
  logic [DATA_WIDTH-1:0]   dvs_q,       dvs_d;
  logic                    qneg_q,      qneg_d;

  // One restoring step; the extra bit keeps the trial subtraction exact
  // when the shifted remainder has its top bit set.
  logic [DATA_WIDTH:0]     rem_shift;
  logic [DATA_WIDTH:0]     trial;
  logic [DATA_WIDTH-1:0]   step_rem;
  logic [DATA_WIDTH-1:0]   step_quo;

  // Next-state, datapath step and result formatting
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    q_out_d     = q_out_q;
`ifdef INT_DIV_REM_EN
    r_out_d     = r_out_q;
    rneg_d      = rneg_q;
`endif
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;

    rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    step_rem  = trial[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    step_quo  = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (B == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            q_out_d     = ALL_ONES;
`ifdef INT_DIV_REM_EN
            r_out_d     = A;
`endif
          end else if (SIGNED && (A == MOST_NEG) && (B == ALL_ONES)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            q_out_d     = A;
`ifdef INT_DIV_REM_EN
            r_out_d     = '0;
`endif
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(DATA_WIDTH);
            rem_d   = '0;
            quo_d   = magnitude(A, SIGNED);
            dvs_d   = magnitude(B, SIGNED);
            qneg_d  = SIGNED & (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
`ifdef INT_DIV_REM_EN
            rneg_d  = SIGNED & A[DATA_WIDTH-1];
`endif
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - 1'b1;
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          q_out_d     = apply_sign(step_quo, qneg_q);
`ifdef INT_DIV_REM_EN
          r_out_d     = apply_sign(step_rem, rneg_q);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // FSM, counter and result registers; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_out_q     <= '0;
`ifdef INT_DIV_REM_EN
      r_out_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      q_out_q     <= q_out_d;
`ifdef INT_DIV_REM_EN
      r_out_q     <= r_out_d;
`endif
    end
  end

  // Working registers; only meaningful while CALC, so they need no reset
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    qneg_q <= qneg_d;
`ifdef INT_DIV_REM_EN
    rneg_q <= rneg_d;
`endif
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = q_out_q;
`ifdef INT_DIV_REM_EN
  assign R         = r_out_q;
`else
  assign R         = '0;
`endif

endmodule

// File: tb/tb_int_div_seq.sv
// Self-checking bench for int_div_seq (DATA_WIDTH = 32). Expected results
// are pushed to a scoreboard queue at accept and popped on each result
// handshake; scenario tasks also check latency, handshakes and reset.
// Works with or without INT_DIV_REM_EN (expected R follows the macro).
module tb_int_div_seq;

  localparam int W = 32;
`ifdef INT_DIV_REM_EN
  localparam logic [W-1:0] RMASK = '1;
`else
  localparam logic [W-1:0] RMASK = '0;
`endif
  localparam logic [W-1:0] MIN  = 32'h8000_0000;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [7:0]   lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sgn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [W-1:0] r;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  int_div_seq #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .SIGNED   (sgn),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Q        (q),
    .R        (r)
  );

  // Reference model built on the language's own division operators.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    if (y == '0) begin
      e.q = ONES;
      e.r = x;
    end else if (s && x == MIN && y == ONES) begin
      e.q = x;
      e.r = '0;
    end else if (s) begin
      e.q = $signed(x) / $signed(y);
      e.r = $signed(x) % $signed(y);
    end else begin
      e.q = x / y;
      e.r = x % y;
    end
    e.r = e.r & RMASK;
    return e;
  endfunction

  function automatic logic [7:0] exp_lat(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    return ((y == '0) || (s && x == MIN && y == ONES)) ? 8'd0 : 8'd32;
  endfunction

  // Scoreboard: a result handshake happens on the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_result: got Q=%h R=%h, required no result", q, r);
      end else begin
        mon_e = sb.pop_front();
        if (q !== mon_e.q || r !== mon_e.r) begin
          miscompares++;
          $display("FAIL scoreboard: got Q=%h R=%h, required Q=%h R=%h", q, r, mon_e.q, mon_e.r);
        end
      end
    end
  end

  // Present operands once the block is ready; returns #1 after the accept edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit push);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got in_ready=%b, required 1", in_ready);
    end
    a = x; b = y; sgn = s; in_valid = 1'b1;
    @(posedge clk); #1;
    if (push) sb.push_back(model(x, y, s));
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sgn = 1'($urandom_range(0, 1));
  endtask

  // Number of edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sgn = 1'b0;
    #12;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    vectors++;
    if (q !== '0 || r !== '0) begin miscompares++; $display("FAIL reset_qr: got Q=%h R=%h, required 0 0", q, r); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_idle_out_valid: got %b, required 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    vec_t t[6] = '{
      '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        8'd32},
      '{ONES,         32'd3,        1'b0, 32'h5555_5555, 32'd0,       8'd32},
      '{MIN,          32'h8000_0001, 1'b0, 32'd0,       MIN,          8'd32},
      '{ONES,         32'd1,        1'b0, ONES,         32'd0,        8'd32},
      '{MIN,          ONES,         1'b0, 32'd0,        MIN,          8'd32},
      '{ONES,         ONES,         1'b0, 32'd1,        32'd0,        8'd32}
    };
    int lat;
    out_ready = 1'b1;
    foreach (t[i]) begin
      send(t[i].a, t[i].b, t[i].s, 1'b1);
      wait_out(lat);
      vectors++;
      if (lat != int'(t[i].lat)) begin miscompares++; $display("FAIL unsigned_latency[%0d]: got %0d, required %0d", i, lat, t[i].lat); end
      vectors++;
      if (q !== t[i].q || r !== (t[i].r & RMASK)) begin
        miscompares++;
        $display("FAIL unsigned_result[%0d]: got Q=%h R=%h, required Q=%h R=%h", i, q, r, t[i].q, t[i].r & RMASK);
      end
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL unsigned_release[%0d]: got in_ready=%b out_valid=%b, required 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_signed();
    vec_t t[7] = '{
      '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, ONES,          8'd32},
      '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         8'd32},
      '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3,         ONES,          8'd32},
      '{MIN,           32'd2,         1'b1, 32'hC000_0000, 32'd0,         8'd32},
      '{MIN,           32'd1,         1'b1, MIN,           32'd0,         8'd32},
      '{ONES,          ONES,          1'b1, 32'd1,         32'd0,         8'd32},
      '{32'hFFFF_FF9C, 32'd7,         1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 8'd32}
    };
    int lat;
    out_ready = 1'b1;
    foreach (t[i]) begin
      send(t[i].a, t[i].b, t[i].s, 1'b1);
      wait_out(lat);
      vectors++;
      if (lat != int'(t[i].lat)) begin miscompares++; $display("FAIL signed_latency[%0d]: got %0d, required %0d", i, lat, t[i].lat); end
      vectors++;
      if (q !== t[i].q || r !== (t[i].r & RMASK)) begin
        miscompares++;
        $display("FAIL signed_result[%0d]: got Q=%h R=%h, required Q=%h R=%h", i, q, r, t[i].q, t[i].r & RMASK);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_special();
    vec_t t[4] = '{
      '{32'd5,         32'd0, 1'b0, ONES, 32'd5,         8'd0},
      '{32'd5,         32'd0, 1'b1, ONES, 32'd5,         8'd0},
      '{32'hFFFF_FFFB, 32'd0, 1'b1, ONES, 32'hFFFF_FFFB, 8'd0},
      '{MIN,           ONES,  1'b1, MIN,  32'd0,         8'd0}
    };
    int lat;
    out_ready = 1'b1;
    foreach (t[i]) begin
      send(t[i].a, t[i].b, t[i].s, 1'b1);
      wait_out(lat);
      vectors++;
      if (lat != int'(t[i].lat)) begin miscompares++; $display("FAIL special_latency[%0d]: got %0d, required %0d", i, lat, t[i].lat); end
      vectors++;
      if (q !== t[i].q || r !== (t[i].r & RMASK)) begin
        miscompares++;
        $display("FAIL special_result[%0d]: got Q=%h R=%h, required Q=%h R=%h", i, q, r, t[i].q, t[i].r & RMASK);
      end
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL special_release[%0d]: got in_ready=%b, required 1", i, in_ready); end
    end
  endtask

  task automatic test_hold();
    int lat;
    out_ready = 1'b0;
    send(ONES, 32'd2, 1'b0, 1'b1);
    // Competing operands while busy must be ignored.
    in_valid = 1'b1; a = 32'd3; b = 32'd1; sgn = 1'b1;
    wait_out(lat);
    vectors++;
    if (lat != 32) begin miscompares++; $display("FAIL hold_latency: got %0d, required 32", lat); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== 32'h7FFF_FFFF || r !== (32'd1 & RMASK)) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got out_valid=%b in_ready=%b Q=%h R=%h, required 1 0 %h %h",
                 i, out_valid, in_ready, q, r, 32'h7FFF_FFFF, 32'd1 & RMASK);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    out_ready = 1'b1;
    send(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || q !== '0 || r !== '0) begin
      miscompares++;
      $display("FAIL reset_calc: got out_valid=%b Q=%h R=%h, required 0 0 0", out_valid, q, r);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_calc_in_ready: got %b, required 1", in_ready); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL reset_calc_stale: got out_valid=1, required 0"); end
    @(posedge clk); #1;

    // Reset while a finished result is waiting for the consumer.
    out_ready = 1'b0;
    send(32'd100, 32'd7, 1'b0, 1'b0);
    wait_out(lat);
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL reset_done_pre: got out_valid=%b, required 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || q !== '0) begin
      miscompares++;
      $display("FAIL reset_done: got out_valid=%b Q=%h, required 0 0", out_valid, q);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL reset_done_stale: got out_valid=1, required 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y;
    logic         s;
    int           lat;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      x = $urandom;
      s = 1'($urandom_range(0, 1));
      case (i % 4)
        0:       y = 32'($urandom_range(1, 15));
        1:       y = $urandom;
        2:       y = {16'h0, 16'($urandom)};
        default: y = (i == 7) ? 32'd0 : ~32'($urandom_range(0, 9));
      endcase
      if (i == 11) begin x = MIN; y = ONES; s = 1'b1; end
      send(x, y, s, 1'b1);
      wait_out(lat);
      vectors++;
      if (lat != int'(exp_lat(x, y, s))) begin
        miscompares++;
        $display("FAIL b2b_latency[%0d]: got %0d, required %0d", i, lat, exp_lat(x, y, s));
      end
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_release[%0d]: got in_ready=%b, required 1", i, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_div_seq.md
INT_DIV_SEQ -- requirements
Module: int_div_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have in_valid  input  1  operands A/B/SIGNED valid.
REQ-005 SHALL have in_ready  output  1  block can accept operands.
REQ-006 SHALL have A  input  DATA_WIDTH  dividend.
REQ-007 SHALL have B  input  DATA_WIDTH  divisor.
REQ-008 SHALL have SIGNED  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have out_valid  output  1  Q/R valid.
REQ-010 SHALL have out_ready  input  1  consumer takes result.
REQ-011 SHALL have Q  output  DATA_WIDTH  quotient.
REQ-012 SHALL have R  output  DATA_WIDTH  remainder (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept SHALL occur on an edge with IDLE and in_valid=1; A, B, SIGNED are captured then, and later input changes have no effect.
REQ-016 On accept with B=0, next state SHALL be DONE with Q=all ones, R=A (signed and unsigned).
REQ-017 On accept with SIGNED=1, A=most-negative, B=all ones, next state SHALL be DONE with Q=A, R=0.
REQ-018 All other accepts SHALL enter CALC with a bit counter loaded to DATA_WIDTH.
REQ-019 CALC SHALL run restoring division on operand magnitudes, one quotient bit per edge, MSB first; the counter decrements each edge.
REQ-020 On the edge that processes the last bit, sign correction SHALL apply and the state SHALL move to DONE; out_valid is thus 1 exactly DATA_WIDTH edges after the accept edge.
REQ-021 Signed results SHALL truncate toward zero: Q negative iff A, B signs differ, and a nonzero R SHALL take the sign of A.
REQ-022 Q and R SHALL hold stable in DONE until an edge with out_ready=1, which SHALL return the state to IDLE.
REQ-023 No operand SHALL be accepted on the result-handshake edge; in_ready SHALL rise on the following cycle.
REQ-024 in_valid while not in IDLE SHALL be ignored and SHALL NOT corrupt the running operation.
REQ-025 Internal arithmetic SHALL use DATA_WIDTH+1 bits for the partial remainder to avoid overflow on unsigned operands with MSB set.

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, force state IDLE, counter 0, Q=0, R=0, out_valid=0.
REQ-027 Reset during CALC or DONE SHALL discard the operation; no out_valid SHALL follow it.
REQ-028 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-029 Macro INT_DIV_REM_EN SHALL control the remainder output.
REQ-030 With INT_DIV_REM_EN defined, R SHALL carry the remainder per REQ-016, REQ-017 and REQ-021.
REQ-031 Without INT_DIV_REM_EN, R SHALL be constant 0 and no remainder output register SHALL be instantiated; Q and latency SHALL be unchanged.

Verification (DATA_WIDTH=32, INT_DIV_REM_EN defined unless noted)
REQ-032 Unsigned A=100, B=7, out_ready=1 -> after 32 edges Q=14, R=2; next cycle in_ready=1.
REQ-033 Signed A=-7, B=2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1); signed A=7, B=-2 -> Q=-3, R=1.
REQ-034 A=5, B=0 (SIGNED 0 and 1) -> one edge later Q=0xFFFFFFFF, R=5; signed A=0x80000000, B=0xFFFFFFFF -> one edge later Q=0x80000000, R=0.
REQ-035 Unsigned A=0xFFFFFFFF, B=2, out_ready held 0 for 5 cycles -> Q=0x7FFFFFFF, R=1 held stable with out_valid=1 until out_ready=1; new in_valid during hold ignored.
REQ-036 rst pulsed 10 cycles into CALC -> out_valid=0, Q=R=0 immediately, in_ready=1 after release, no stale result appears.
REQ-037 Without INT_DIV_REM_EN, A=100, B=7 -> Q=14, R=0, same 32-edge latency.
